traffic_sched: RTL and testbench
================================

TRAFFIC_SCHED -- requirements
Module: traffic_sched

Interface
REQ-001 SHALL: clk  input  1  rising-edge system clock.
REQ-002 SHALL: reset_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL: i_enable  input  1  run request for the intersection; level.
REQ-004 SHALL: i_emg  input  1  emergency preempt request; level.
REQ-005 SHALL: i_ped_req  input  2  pedestrian buttons; bit0 road A, bit1 road B; level or pulse.
REQ-006 SHALL: o_start  output  1  drives i_start of both light controllers.
REQ-007 SHALL: o_sync_n  output  1  active-low phase-load strobe to both light controllers' reset_n; A loads 0, B loads 34.
REQ-008 SHALL: o_cycle  output  7  shadow of road-A phase counter.
REQ-009 SHALL: o_emg_active  output  1  high in PREEMPT; selects the external all-red override.
REQ-010 SHALL: o_ped_wait  output  2  latched pending pedestrian request per road.
REQ-011 SHALL: o_ped_serve  output  2  one-cycle pulse when the road's walk phase is granted.
REQ-012 SHALL: o_state  output  3  current state encoding.

Function
REQ-013 SHALL: states IDLE=000, SYNC=001, RUN=010, DRAIN=011, PREEMPT=100; all other codes go to IDLE on the next clock.
REQ-014 SHALL: IDLE: o_start=0, o_sync_n=1, o_cycle=0; i_enable=1 and i_emg=0 -> SYNC.
REQ-015 SHALL: SYNC lasts exactly 1 cycle: o_start=1, o_sync_n=0, o_cycle<=0; next state RUN.
REQ-016 SHALL: RUN: o_start=1, o_sync_n=1; o_cycle increments by 1 each clock; 68 wraps to 1, never to 0.
REQ-017 SHALL: RUN with i_emg=1 -> DRAIN.
REQ-018 SHALL: DRAIN: same outputs and counting as RUN; on the clock where o_cycle is 34 or 68 (end of a yellow) -> PREEMPT; i_emg falling while in DRAIN does not abort the drain.
REQ-019 SHALL: PREEMPT: o_start=0, o_sync_n=1, o_emg_active=1, o_cycle<=0; hold while i_emg=1; i_emg=0 -> SYNC if i_enable=1, else IDLE.
REQ-020 SHALL: i_enable=0 in any state -> IDLE on the next clock; this takes priority over i_emg and over the drain condition.
REQ-021 SHALL: o_ped_wait[i] is set the clock after i_ped_req[i]=1 in any state except IDLE; in IDLE it is held at 0.
REQ-022 SHALL: o_ped_serve[0] is 1 when state is RUN and o_cycle==35 and o_ped_wait[0]=1; o_ped_serve[1] is the same with o_cycle==1 and o_ped_wait[1]=1.
REQ-023 SHALL: o_ped_serve[i]=1 clears o_ped_wait[i] on the next clock; if i_ped_req[i] is also 1 in that cycle, clear wins.
REQ-024 SHALL: requests are not served in DRAIN or PREEMPT; pending o_ped_wait bits persist through PREEMPT and SYNC.
REQ-025 SHALL: o_state, o_emg_active, o_start and o_sync_n are decoded from registered state only, with no input-to-output combinational path.

Reset
REQ-026 SHALL: reset_n=0 at a clock edge forces state IDLE, o_cycle=0, o_ped_wait=00.
REQ-027 SHALL: during reset, o_start=0, o_sync_n=1, o_emg_active=0, o_ped_serve=00, o_state=000.
REQ-028 SHALL: reset asserted mid-RUN, DRAIN or PREEMPT behaves identically and discards pending requests.

Configuration
REQ-029 SHALL: macro TRAFFIC_SCHED_PED_EN defined -> pedestrian latch and serve logic are present per REQ-021..024.
REQ-030 SHALL: macro TRAFFIC_SCHED_PED_EN undefined -> o_ped_wait=00 and o_ped_serve=00 constantly; i_ped_req ignored; all other behaviour unchanged.

Verification
REQ-031 SHALL: reset, then i_enable=1 -> o_state 000 -> 001 (o_sync_n=0 for 1 cycle) -> 010; o_cycle 0,1,2..68,1.
REQ-032 SHALL: RUN with i_emg pulsed at o_cycle=10 -> DRAIN through o_cycle=34, PREEMPT next clock with o_start=0 and o_emg_active=1; i_emg=0 -> SYNC -> RUN from o_cycle=0.
REQ-033 SHALL: i_ped_req=01 at o_cycle=5 -> o_ped_wait=01 at 6; o_ped_serve=01 at o_cycle=35; o_ped_wait=00 at 36.
REQ-034 SHALL: i_ped_req=10 held high through o_cycle=1 -> one serve pulse, wait cleared; re-latched the following cycle since the request is still high.
REQ-035 SHALL: i_enable=0 during DRAIN with i_emg=1 -> IDLE next clock, o_start=0, o_emg_active=0.
REQ-036 SHALL: macro undefined, i_ped_req=11 throughout a full period -> o_ped_wait=00 and o_ped_serve=00 at every cycle.

Source files
------------

// File: rtl/traffic_sched.sv
// Intersection scheduler: sequences start/sync of two light controllers, emergency preemption and pedestrian walks.
// Pedestrian latch/serve logic is present only when TRAFFIC_SCHED_PED_EN is defined.
module traffic_sched (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_enable,
   input  logic       i_emg,
   input  logic [1:0] i_ped_req,
   output logic       o_start,
   output logic       o_sync_n,
   output logic [6:0] o_cycle,
   output logic       o_emg_active,
   output logic [1:0] o_ped_wait,
   output logic [1:0] o_ped_serve,
   output logic [2:0] o_state
);

   localparam logic [2:0] ST_IDLE    = 3'b000;
   localparam logic [2:0] ST_SYNC    = 3'b001;
   localparam logic [2:0] ST_RUN     = 3'b010;
   localparam logic [2:0] ST_DRAIN   = 3'b011;
   localparam logic [2:0] ST_PREEMPT = 3'b100;

   // Phase 34 and 68 are the last cycles of road A's and road B's yellow.
   localparam logic [6:0] CYC_YEL_A  = 7'd34;
   localparam logic [6:0] CYC_LAST   = 7'd68;
   localparam logic [6:0] CYC_WALK_A = 7'd35;
   localparam logic [6:0] CYC_WALK_B = 7'd1;

   logic [2:0] state_q, state_d;
   logic [6:0] cycle_q, cycle_d;
   logic       count_now, count_next;

   always_comb begin
      state_d = ST_IDLE;
      if (i_enable) begin
         case (state_q)
            ST_IDLE:    state_d = i_emg ? ST_IDLE : ST_SYNC;
            ST_SYNC:    state_d = ST_RUN;
            ST_RUN:     state_d = i_emg ? ST_DRAIN : ST_RUN;
            ST_DRAIN:   state_d = ((cycle_q == CYC_YEL_A) || (cycle_q == CYC_LAST)) ? ST_PREEMPT : ST_DRAIN;
            ST_PREEMPT: state_d = i_emg ? ST_PREEMPT : ST_SYNC;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   // The counter only advances while staying inside RUN/DRAIN, so every other state shows phase 0.
   assign count_now  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign count_next = (state_d == ST_RUN) || (state_d == ST_DRAIN);

   always_comb begin
      cycle_d = 7'd0;
      if (count_now && count_next) begin
         cycle_d = (cycle_q == CYC_LAST) ? 7'd1 : cycle_q + 7'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cycle_q <= 7'd0;
      end else begin
         state_q <= state_d;
         cycle_q <= cycle_d;
      end
   end

   assign o_state      = state_q;
   assign o_cycle      = cycle_q;
   assign o_start      = (state_q == ST_SYNC) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign o_sync_n     = (state_q != ST_SYNC);
   assign o_emg_active = (state_q == ST_PREEMPT);

`ifdef TRAFFIC_SCHED_PED_EN
   logic [1:0] ped_wait_q, ped_wait_d;
   logic [1:0] ped_serve;

   always_comb begin
      ped_serve = 2'b00;
      if (state_q == ST_RUN) begin
         ped_serve[0] = ped_wait_q[0] && (cycle_q == CYC_WALK_A);
         ped_serve[1] = ped_wait_q[1] && (cycle_q == CYC_WALK_B);
      end
      // A grant clears the latch even if the button is still pressed that cycle.
      if (state_q == ST_IDLE) begin
         ped_wait_d = 2'b00;
      end else begin
         ped_wait_d = (ped_wait_q | i_ped_req) & ~ped_serve;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ped_wait_q <= 2'b00;
      end else begin
         ped_wait_q <= ped_wait_d;
      end
   end

   assign o_ped_wait  = ped_wait_q;
   assign o_ped_serve = ped_serve;
`else
   logic unused_ped;
   assign unused_ped  = ^i_ped_req;
   assign o_ped_wait  = 2'b00;
   assign o_ped_serve = 2'b00;
`endif

endmodule

// File: tb/tb_traffic_sched.sv
// Bench for traffic_sched: reset/transition vector table plus hand-written phase, preempt and pedestrian sequences.
// Expectations for pedestrian outputs follow TRAFFIC_SCHED_PED_EN as compiled.
module tb_traffic_sched;

   localparam logic [2:0] S_IDLE  = 3'b000;
   localparam logic [2:0] S_SYNC  = 3'b001;
   localparam logic [2:0] S_RUN   = 3'b010;
   localparam logic [2:0] S_DRAIN = 3'b011;
   localparam logic [2:0] S_PRE   = 3'b100;
`ifdef TRAFFIC_SCHED_PED_EN
   localparam bit PED = 1'b1;
`else
   localparam bit PED = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       i_enable = 1'b0;
   logic       i_emg = 1'b0;
   logic [1:0] i_ped_req = 2'b00;
   logic       o_start, o_sync_n, o_emg_active;
   logic [6:0] o_cycle;
   logic [1:0] o_ped_wait, o_ped_serve;
   logic [2:0] o_state;

   int tests = 0;
   int fails = 0;
   logic [16:0] exp_q[$];

   typedef struct {
      logic       rst_n;
      logic       en;
      logic       emg;
      logic [1:0] ped;
      logic [2:0] st;
      logic [6:0] cyc;
   } vec_t;
   vec_t vecs[15];

   traffic_sched dut (
      .clk(clk), .reset_n(reset_n), .i_enable(i_enable), .i_emg(i_emg),
      .i_ped_req(i_ped_req), .o_start(o_start), .o_sync_n(o_sync_n),
      .o_cycle(o_cycle), .o_emg_active(o_emg_active), .o_ped_wait(o_ped_wait),
      .o_ped_serve(o_ped_serve), .o_state(o_state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   function automatic logic [16:0] pack(input logic [2:0] st, input logic [6:0] cyc,
                                        input logic [1:0] pw, input logic [1:0] ps);
      logic start, sync_n, emga;
      start  = (st == S_SYNC) || (st == S_RUN) || (st == S_DRAIN);
      sync_n = (st != S_SYNC);
      emga   = (st == S_PRE);
      return {st, cyc, start, sync_n, emga, pw, ps};
   endfunction

   // Drive one cycle of inputs, queue the expected post-edge outputs, then compare after the edge.
   task automatic step(input logic rst_n, input logic en, input logic emg, input logic [1:0] ped,
                       input logic [2:0] st, input logic [6:0] cyc,
                       input logic [1:0] pw, input logic [1:0] ps, input string name);
      logic [16:0] got, exp;
      reset_n   = rst_n;
      i_enable  = en;
      i_emg     = emg;
      i_ped_req = ped;
      exp_q.push_back(pack(st, cyc, PED ? pw : 2'b00, PED ? ps : 2'b00));
      @(posedge clk);
      #1;
      got = {o_state, o_cycle, o_start, o_sync_n, o_emg_active, o_ped_wait, o_ped_serve};
      exp = exp_q.pop_front();
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s @%0t: got st=%b cyc=%0d start=%b sync_n=%b emg=%b pw=%b ps=%b, want st=%b cyc=%0d start=%b sync_n=%b emg=%b pw=%b ps=%b",
                  name, $time, got[16:14], got[13:7], got[6], got[5], got[4], got[3:2], got[1:0],
                  exp[16:14], exp[13:7], exp[6], exp[5], exp[4], exp[3:2], exp[1:0]);
      end
   endtask

   task automatic run(input logic emg, input logic [1:0] ped, input logic [2:0] st, input logic [6:0] cyc,
                      input logic [1:0] pw, input logic [1:0] ps, input string name);
      step(1'b1, 1'b1, emg, ped, st, cyc, pw, ps, name);
   endtask

   initial begin
      vecs[0]  = '{1'b0, 1'b1, 1'b0, 2'b11, S_IDLE,  7'd0};
      vecs[1]  = '{1'b0, 1'b1, 1'b1, 2'b00, S_IDLE,  7'd0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'b00, S_IDLE,  7'd0};
      vecs[3]  = '{1'b1, 1'b1, 1'b1, 2'b00, S_IDLE,  7'd0};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 2'b11, S_SYNC,  7'd0};
      vecs[5]  = '{1'b1, 1'b1, 1'b1, 2'b00, S_RUN,   7'd0};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 2'b00, S_RUN,   7'd1};
      vecs[7]  = '{1'b1, 1'b0, 1'b1, 2'b00, S_IDLE,  7'd0};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 2'b00, S_SYNC,  7'd0};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 2'b00, S_IDLE,  7'd0};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 2'b00, S_SYNC,  7'd0};
      vecs[11] = '{1'b1, 1'b1, 1'b0, 2'b00, S_RUN,   7'd0};
      vecs[12] = '{1'b1, 1'b1, 1'b1, 2'b00, S_DRAIN, 7'd1};
      vecs[13] = '{1'b1, 1'b1, 1'b0, 2'b00, S_DRAIN, 7'd2};
      vecs[14] = '{1'b0, 1'b1, 1'b1, 2'b00, S_IDLE,  7'd0};

      for (int i = 0; i < 15; i++) begin
         step(vecs[i].rst_n, vecs[i].en, vecs[i].emg, vecs[i].ped, vecs[i].st, vecs[i].cyc,
              2'b00, 2'b00, $sformatf("vec%0d", i));
      end

      // Start-up and full phase period with wrap 68 -> 1.
      run(1'b0, 2'b00, S_SYNC, 7'd0, 2'b00, 2'b00, "sync");
      run(1'b0, 2'b00, S_RUN, 7'd0, 2'b00, 2'b00, "run_first");
      for (int k = 1; k <= 68; k++) run(1'b0, 2'b00, S_RUN, 7'(k), 2'b00, 2'b00, "run_count");
      run(1'b0, 2'b00, S_RUN, 7'd1, 2'b00, 2'b00, "run_wrap");
      for (int k = 2; k <= 10; k++) run(1'b0, 2'b00, S_RUN, 7'(k), 2'b00, 2'b00, "run_count2");

      // Emergency pulse at phase 10: drain to 34, preempt, then resynchronise.
      run(1'b1, 2'b00, S_DRAIN, 7'd11, 2'b00, 2'b00, "drain_enter");
      for (int k = 12; k <= 34; k++) run(1'b0, 2'b00, S_DRAIN, 7'(k), 2'b00, 2'b00, "drain_count");
      run(1'b0, 2'b00, S_PRE, 7'd0, 2'b00, 2'b00, "preempt_34");
      run(1'b1, 2'b00, S_PRE, 7'd0, 2'b00, 2'b00, "preempt_hold");
      run(1'b1, 2'b00, S_PRE, 7'd0, 2'b00, 2'b00, "preempt_hold2");
      run(1'b0, 2'b00, S_SYNC, 7'd0, 2'b00, 2'b00, "preempt_exit");
      run(1'b0, 2'b00, S_RUN, 7'd0, 2'b00, 2'b00, "rerun");
      for (int k = 1; k <= 60; k++) run(1'b0, 2'b00, S_RUN, 7'(k), 2'b00, 2'b00, "rerun_count");

      // Drain ending at 68 must preempt rather than wrap.
      run(1'b1, 2'b00, S_DRAIN, 7'd61, 2'b00, 2'b00, "drain2_enter");
      for (int k = 62; k <= 68; k++) run(1'b1, 2'b00, S_DRAIN, 7'(k), 2'b00, 2'b00, "drain2_count");
      run(1'b1, 2'b00, S_PRE, 7'd0, 2'b00, 2'b00, "preempt_68");
      step(1'b1, 1'b0, 1'b1, 2'b00, S_IDLE, 7'd0, 2'b00, 2'b00, "pre_disable");

      // Disable during drain with emergency still asserted.
      run(1'b0, 2'b00, S_SYNC, 7'd0, 2'b00, 2'b00, "sync3");
      run(1'b0, 2'b00, S_RUN, 7'd0, 2'b00, 2'b00, "run3");
      run(1'b1, 2'b00, S_DRAIN, 7'd1, 2'b00, 2'b00, "drain3");
      step(1'b1, 1'b0, 1'b1, 2'b00, S_IDLE, 7'd0, 2'b00, 2'b00, "drain_disable");

      // Pedestrian A request at phase 5, served at 35.
      run(1'b0, 2'b00, S_SYNC, 7'd0, 2'b00, 2'b00, "ped_sync");
      run(1'b0, 2'b00, S_RUN, 7'd0, 2'b00, 2'b00, "ped_run0");
      for (int k = 1; k <= 36; k++) begin
         run(1'b0, (k == 6) ? 2'b01 : 2'b00, S_RUN, 7'(k),
             {1'b0, (k >= 6 && k <= 35)}, {1'b0, (k == 35)}, "ped_a");
      end
      // Pedestrian B held high across phase 1: serve, clear, re-latch.
      for (int n = 37; n <= 71; n++) begin
         run(1'b0, (n >= 61) ? 2'b10 : 2'b00, S_RUN, 7'((n <= 68) ? n : n - 68),
             {(n >= 61 && n != 70), 1'b0}, {(n == 69), 1'b0}, "ped_b");
      end
      run(1'b0, 2'b01, S_RUN, 7'd4, 2'b11, 2'b00, "ped_both");
      for (int k = 5; k <= 34; k++) run(1'b0, 2'b00, S_RUN, 7'(k), 2'b11, 2'b00, "ped_pending");

      // No grant during drain; pending requests survive preempt and sync.
      run(1'b1, 2'b00, S_DRAIN, 7'd35, 2'b11, 2'b00, "ped_no_serve_drain");
      for (int k = 36; k <= 68; k++) run(1'b0, 2'b00, S_DRAIN, 7'(k), 2'b11, 2'b00, "ped_drain");
      run(1'b0, 2'b00, S_PRE, 7'd0, 2'b11, 2'b00, "ped_preempt");
      run(1'b1, 2'b00, S_PRE, 7'd0, 2'b11, 2'b00, "ped_preempt_hold");
      run(1'b0, 2'b00, S_SYNC, 7'd0, 2'b11, 2'b00, "ped_resync");
      run(1'b0, 2'b00, S_RUN, 7'd0, 2'b11, 2'b00, "ped_rerun0");
      run(1'b0, 2'b00, S_RUN, 7'd1, 2'b11, 2'b10, "ped_serve_b2");
      run(1'b0, 2'b00, S_RUN, 7'd2, 2'b01, 2'b00, "ped_b_cleared");

      // Reset mid-preempt discards the pending request.
      run(1'b1, 2'b00, S_DRAIN, 7'd3, 2'b01, 2'b00, "ped_drain2");
      for (int k = 4; k <= 34; k++) run(1'b1, 2'b00, S_DRAIN, 7'(k), 2'b01, 2'b00, "ped_drain2_count");
      run(1'b1, 2'b00, S_PRE, 7'd0, 2'b01, 2'b00, "ped_preempt2");
      step(1'b0, 1'b1, 1'b1, 2'b11, S_IDLE, 7'd0, 2'b00, 2'b00, "rst_in_preempt");

`ifndef TRAFFIC_SCHED_PED_EN
      // Buttons held for a whole period have no effect without the pedestrian option.
      run(1'b0, 2'b11, S_SYNC, 7'd0, 2'b00, 2'b00, "noped_sync");
      run(1'b0, 2'b11, S_RUN, 7'd0, 2'b00, 2'b00, "noped_run0");
      for (int k = 1; k <= 68; k++) run(1'b0, 2'b11, S_RUN, 7'(k), 2'b00, 2'b00, "noped_period");
      run(1'b0, 2'b11, S_RUN, 7'd1, 2'b00, 2'b00, "noped_wrap");
`endif

      step(1'b0, 1'b0, 1'b0, 2'b00, S_IDLE, 7'd0, 2'b00, 2'b00, "final_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
